// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life step sequencer.
// Holds the FSM state enum, the Life rule and the cell-index width helper.
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } life_state_t;

  localparam int LIFE_WIDTH   = 8;
  localparam int LIFE_HEIGHT  = 8;
  localparam int LIFE_COUNT_W = 4;

  // Cell index width for a grid of the given number of cells.
  function automatic int life_idx_w(input int cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

  localparam int LIFE_IDX_W = life_idx_w(LIFE_WIDTH * LIFE_HEIGHT);

  function automatic logic life_rule(input logic alive, input logic [3:0] count);
    return (count == 4'd3) | (alive & (count == 4'd2));
  endfunction

endpackage

// File: rtl/life_neighbour_fetch.sv
// Maps (row, col, grid) to the eight neighbour bits of that cell.
// Define LIFE_TORUS_EN to wrap the grid edges; otherwise off-grid cells read as dead.
module life_neighbour_fetch #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int ROW_W  = $clog2(HEIGHT),
  parameter int COL_W  = $clog2(WIDTH),
  parameter int IDX_W  = $clog2(WIDTH * HEIGHT)
) (
  input  logic [ROW_W-1:0]        row,
  input  logic [COL_W-1:0]        col,
  input  logic [WIDTH*HEIGHT-1:0] grid,
  output logic                    n,
  output logic                    ne,
  output logic                    e,
  output logic                    se,
  output logic                    s,
  output logic                    sw,
  output logic                    w,
  output logic                    nw
);

  logic [7:0] nb;

  // Direction gi: 0=n 1=ne 2=e 3=se 4=s 5=sw 6=w 7=nw (row grows southwards).
  for (genvar gi = 0; gi < 8; gi++) begin : g_dir
    localparam int DR = (gi == 0 || gi == 1 || gi == 7) ? -1 :
                        (gi == 3 || gi == 4 || gi == 5) ?  1 : 0;
    localparam int DC = (gi == 1 || gi == 2 || gi == 3) ?  1 :
                        (gi == 5 || gi == 6 || gi == 7) ? -1 : 0;

    int               r;
    int               c;
    logic             on_grid;
    logic [IDX_W-1:0] idx;
    logic             bit_v;

    always_comb begin
      r = int'(row) + DR;
      c = int'(col) + DC;
`ifdef LIFE_TORUS_EN
      if (r < 0) r = r + HEIGHT;
      else if (r >= HEIGHT) r = r - HEIGHT;
      if (c < 0) c = c + WIDTH;
      else if (c >= WIDTH) c = c - WIDTH;
      on_grid = 1'b1;
`else
      on_grid = (r >= 0) && (r < HEIGHT) && (c >= 0) && (c < WIDTH);
`endif
      idx   = on_grid ? IDX_W'(r * WIDTH + c) : '0;
      bit_v = on_grid & grid[idx];
    end

    assign nb[gi] = bit_v;
  end

  assign {nw, w, sw, s, se, e, ne, n} = nb;

endmodule

// File: rtl/popcount.sv
// Combinational population count of a WIDTH-bit vector.
module popcount #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]   bits,
  output logic [COUNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + COUNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/life_step_sequencer.sv
// Runs one or more Game-of-Life generations, one cell per cycle through a shared popcount.
// Optional wrap-around edges are enabled by defining LIFE_TORUS_EN.
module life_step_sequencer
  import life_pkg::*;
#(
  parameter int WIDTH  = LIFE_WIDTH,
  parameter int HEIGHT = LIFE_HEIGHT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [WIDTH*HEIGHT-1:0] load_grid,
  input  logic                    start,
  input  logic [7:0]              step_count,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH*HEIGHT-1:0] grid_out,
  output logic [15:0]             generation
);

  localparam int N     = WIDTH * HEIGHT;
  localparam int IDX_W = life_idx_w(N);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);

  life_state_t      state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_reg;
  logic [7:0]       remaining_reg;
  logic [N-1:0]     grid_reg;
  logic [N-1:0]     shadow_reg;
  logic [15:0]      generation_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [7:0]              nbr_bits;
  logic [LIFE_COUNT_W-1:0] nbr_count;
  logic                    cell_next;

  life_neighbour_fetch #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .IDX_W (IDX_W)
  ) u_fetch (
    .row (row_reg),
    .col (col_reg),
    .grid(grid_reg),
    .n   (nbr_bits[0]),
    .ne  (nbr_bits[1]),
    .e   (nbr_bits[2]),
    .se  (nbr_bits[3]),
    .s   (nbr_bits[4]),
    .sw  (nbr_bits[5]),
    .w   (nbr_bits[6]),
    .nw  (nbr_bits[7])
  );

  popcount #(
    .WIDTH  (8),
    .COUNT_W(LIFE_COUNT_W)
  ) u_popcount (
    .bits (nbr_bits),
    .count(nbr_count)
  );

  assign cell_next = life_rule(grid_reg[idx_reg], nbr_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      remaining_reg  <= '0;
      grid_reg       <= '0;
      shadow_reg     <= '0;
      generation_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (load) begin
            grid_reg       <= load_grid;
            generation_reg <= '0;
          end else if (start) begin
            remaining_reg <= (step_count == 8'd0) ? 8'd1 : step_count;
            idx_reg       <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          shadow_reg[idx_reg] <= cell_next;
          if (idx_reg == IDX_W'(N - 1)) begin
            state_reg <= ST_COMMIT;
          end else begin
            idx_reg <= idx_reg + 1'b1;
            if (col_reg == COL_W'(WIDTH - 1)) begin
              col_reg <= '0;
              row_reg <= row_reg + 1'b1;
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end

        ST_COMMIT: begin
          grid_reg       <= shadow_reg;
          generation_reg <= generation_reg + 16'd1;
          remaining_reg  <= remaining_reg - 8'd1;
          if (remaining_reg > 8'd1) begin
            idx_reg   <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            state_reg <= ST_SCAN;
          end else begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign grid_out   = grid_reg;
  assign generation = generation_reg;

endmodule

// File: tb/tb_life_step_sequencer.sv
// Self-checking bench for life_step_sequencer (8x8): vector table, corner sequences, random runs.
module tb_life_step_sequencer;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;
  localparam int RUN_LEN = N + 1;

  typedef logic [N-1:0] grid_t;

  typedef struct {
    string name;
    grid_t init;
    int    k;
    grid_t exp_grid;
    int    exp_gen;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  grid_t       load_grid;
  logic        start;
  logic [7:0]  step_count;
  logic        busy;
  logic        done;
  grid_t       grid_out;
  logic [15:0] generation;

  int checks = 0;
  int errors = 0;

  life_step_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_grid (load_grid),
    .start     (start),
    .step_count(step_count),
    .busy      (busy),
    .done      (done),
    .grid_out  (grid_out),
    .generation(generation)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic grid_t mk(input int a, input int b, input int c, input int d);
    grid_t g;
    g = '0;
    if (a >= 0) g[a] = 1'b1;
    if (b >= 0) g[b] = 1'b1;
    if (c >= 0) g[c] = 1'b1;
    if (d >= 0) g[d] = 1'b1;
    return g;
  endfunction

  // Reference: count the eight neighbours of every cell on a 2-D view of the grid.
  function automatic grid_t life_model(input grid_t g);
    grid_t nx;
    nx = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
`ifdef LIFE_TORUS_EN
            rr = (rr + H) % H;
            cc = (cc + W) % W;
`endif
            if (rr >= 0 && rr < H && cc >= 0 && cc < W) cnt += int'(g[rr * W + cc]);
          end
        end
        nx[r * W + c] = (cnt == 3) || (g[r * W + c] && cnt == 2);
      end
    end
    return nx;
  endfunction

  task automatic do_load(input grid_t g);
    @(negedge clk);
    load      = 1'b1;
    load_grid = g;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Start a run; optionally pulse start+load in cycle inject_at. Checks busy profile and done timing.
  task automatic run_gen(input string name, input int k, input int inject_at, input grid_t inj_grid);
    int keff, done_cyc, first_done, done_cnt, busy_err;
    keff     = (k == 0) ? 1 : k;
    done_cyc = keff * RUN_LEN + 1;
    first_done = -1;
    done_cnt = 0;
    busy_err = 0;
    @(negedge clk);
    start      = 1'b1;
    step_count = 8'(k);
    @(posedge clk);
    for (int c = 1; c <= done_cyc + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      load  = 1'b0;
      if (c == inject_at) begin
        start      = 1'b1;
        load       = 1'b1;
        load_grid  = inj_grid;
        step_count = 8'd5;
      end
      if (busy !== ((c >= 1) && (c < done_cyc))) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
      end
    end
    start = 1'b0;
    load  = 1'b0;
    chk({name, "_busy_profile"}, 64'(busy_err), 64'd0);
    chk({name, "_done_cycle"}, 64'(first_done), 64'(done_cyc));
    chk({name, "_done_count"}, 64'(done_cnt), 64'd1);
    $display("run %s k=%0d done_cycle=%0d grid=%h gen=%0d", name, k, first_done, grid_out, generation);
  endtask

  vec_t  vecs[6];
  grid_t blinker, blinker_v, block, edge_g, edge_exp, g, exp_g;
  int    k, kk;

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; load_grid = '0; step_count = 8'd0;

    blinker   = mk(26, 27, 28, -1);
    blinker_v = mk(19, 27, 35, -1);
    block     = mk(9, 10, 17, 18);
    edge_g    = mk(0, 1, 7, -1);
`ifdef LIFE_TORUS_EN
    edge_exp  = mk(0, 8, 56, -1);
`else
    edge_exp  = '0;
`endif
    vecs[0] = '{"blinker",    blinker,         1, blinker_v, 1};
    vecs[1] = '{"still_life", block,           3, block,     3};
    vecs[2] = '{"edge",       edge_g,          1, edge_exp,  1};
    vecs[3] = '{"blinker_x2", blinker,         2, blinker,   2};
    vecs[4] = '{"lone_cell",  mk(36, -1, -1, -1), 1, '0,     1};
    vecs[5] = '{"step_zero",  blinker,         0, blinker_v, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_grid", grid_out, 64'd0);
    chk("reset_gen", 64'(generation), 64'd0);

    foreach (vecs[i]) begin
      do_load(vecs[i].init);
      chk({vecs[i].name, "_loaded"}, grid_out, vecs[i].init);
      run_gen(vecs[i].name, vecs[i].k, 0, '0);
      chk({vecs[i].name, "_grid"}, grid_out, vecs[i].exp_grid);
      chk({vecs[i].name, "_gen"}, 64'(generation), 64'(vecs[i].exp_gen));
    end

    // Requests arriving mid-run are dropped.
    do_load(blinker);
    run_gen("ignored_req", 1, 20, block);
    chk("ignored_req_grid", grid_out, blinker_v);
    chk("ignored_req_gen", 64'(generation), 64'd1);

    // Simultaneous load and start in IDLE: load wins.
    @(negedge clk);
    load = 1'b1; start = 1'b1; step_count = 8'd1; load_grid = block;
    @(posedge clk);
    begin
      int bad;
      bad = 0;
      for (int c = 1; c <= 70; c++) begin
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        if (busy !== 1'b0 || done !== 1'b0) bad++;
      end
      chk("load_start_grid", grid_out, block);
      chk("load_start_gen", 64'(generation), 64'd0);
      chk("load_start_quiet", 64'(bad), 64'd0);
      $display("seq load_start grid=%h gen=%0d", grid_out, generation);
    end

    // Reset in cycle 30 of a run aborts it.
    do_load(blinker);
    @(negedge clk);
    start = 1'b1; step_count = 8'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_grid", grid_out, 64'd0);
    chk("abort_gen", 64'(generation), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    begin
      int bad;
      bad = 0;
      for (int c = 0; c < 70; c++) begin
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0) bad++;
      end
      chk("abort_quiet", 64'(bad), 64'd0);
      $display("seq abort grid=%h gen=%0d", grid_out, generation);
    end

    // Random grids against the reference model; generation accumulates across unloaded runs.
    for (int it = 0; it < 8; it++) begin
      g = {$urandom(), $urandom()} & {$urandom(), $urandom()} | {$urandom(), $urandom()} & {$urandom(), $urandom()};
      k = int'($urandom_range(1, 3));
      do_load(g);
      exp_g = g;
      for (int s = 0; s < k; s++) exp_g = life_model(exp_g);
      run_gen("random", k, 0, '0);
      chk("random_grid", grid_out, exp_g);
      chk("random_gen", 64'(generation), 64'(k));
      if (it == 7) begin
        kk = int'($urandom_range(1, 2));
        for (int s = 0; s < kk; s++) exp_g = life_model(exp_g);
        run_gen("random_chain", kk, 0, '0);
        chk("random_chain_grid", grid_out, exp_g);
        chk("random_chain_gen", 64'(generation), 64'(k + kk));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_step_sequencer.md
# life_step_sequencer

Sequences one generation step (or a run of steps) of a Game-of-Life grid held in on-chip registers. Scans the grid one cell per cycle through a single shared `popcount` neighbour counter, applies the Life rule, and accumulates the next-generation grid in a shadow buffer. Commits the shadow buffer atomically at the end of each generation. Sits between the host/load logic and the display/readout path.

## Interface
- `WIDTH`, 8: grid columns, ≥3.
- `HEIGHT`, 8: grid rows, ≥3.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  replaces the current grid with `load_grid`; honoured only in IDLE.
- `load_grid`  in  WIDTH*HEIGHT  new grid. Bit index = row*WIDTH + col; 1 = alive.
- `start`  in  1  starts a run; honoured only in IDLE.
- `step_count`  in  8  generations to run; sampled with `start`; 0 is treated as 1.
- `busy`  out  1  high in SCAN and COMMIT.
- `done`  out  1  one-cycle pulse when a run completes.
- `grid_out`  out  WIDTH*HEIGHT  current committed grid.
- `generation`  out  16  generations committed since the last load or reset; wraps 0xFFFF→0.

## Operation
- States: IDLE, SCAN, COMMIT, DONE.
- IDLE:
  - `load` → `grid_out` = `load_grid`, `generation` = 0, stay in IDLE.
  - Otherwise `start` → latch `step_count` (0→1) into the remaining counter, clear the cell index, go to SCAN.
  - `load` and `start` in the same cycle: load wins and start is dropped.
- SCAN:
  - Cell index runs 0..N-1, where N = WIDTH*HEIGHT, row-major, one cell per cycle.
  - The 8 neighbours of the indexed cell are read from the committed grid and fed to `popcount`.
  - Next-state bit = (count==3) | (alive & count==2). It is written to the shadow buffer at the same index.
  - Neighbours outside the grid read as dead unless the torus option is compiled in.
  - After index N-1, go to COMMIT.
- COMMIT:
  - `grid_out` ← shadow buffer, `generation` += 1, remaining counter −1.
  - Remaining counter still nonzero → SCAN, with the index cleared. Otherwise → DONE.
- DONE: `done`=1 for exactly this cycle, then IDLE.
- `start` and `load` outside IDLE are ignored and not queued.
- `grid_out` changes only at COMMIT or on a load, so it is stable throughout SCAN.
- Reset values: state IDLE, `busy`=0, `done`=0, `grid_out`=0, `generation`=0, cell index 0, remaining counter 0, shadow buffer 0.
- Reset mid-run aborts the run immediately. The partial shadow buffer is discarded and no `done` pulse is produced.

## Timing
- Label the `start`-accept edge as cycle 0.
  - SCAN occupies cycles 1..N.
  - COMMIT occurs in cycle N+1.
  - For k generations, SCAN/COMMIT repeats k times. DONE falls in cycle k*(N+1)+1.
- Example, 8×8 with k=1: COMMIT in cycle 65, `done` in cycle 66, next `start` accepted in cycle 67.
- Neighbour fetch, popcount and rule evaluation are combinational within one cycle. There is no pipeline bubble between cells.
- `busy` is registered and equals (state==SCAN || state==COMMIT).

## Configuration
- `LIFE_TORUS_EN` defined:
  - Neighbour coordinates wrap modulo WIDTH and HEIGHT.
  - Column −1 → WIDTH-1 and WIDTH → 0; rows wrap the same way.
- Undefined: off-grid neighbours are constant 0.

## Structure
- Shared package `life_pkg` holds:
  - the state enum `life_state_t`;
  - the function `life_rule(alive, count[3:0])`;
  - the index-width constant derived from $clog2(WIDTH*HEIGHT).
- One instance of the existing `popcount` module is the shared datapath.
- A combinational sub-module `life_neighbour_fetch` maps (row, col, grid) to the eight n/ne/e/se/s/sw/w/nw bits and contains the `LIFE_TORUS_EN` edge logic.

## Test plan
- Blinker (8×8): load bits {26,27,28}, `start` with `step_count`=1 → `done` in cycle 66, `grid_out` bits {19,27,35} only, `generation`=1.
- Still life: load block {9,10,17,18}, `step_count`=3 → `done` in cycle 196, grid unchanged, `generation`=3. Also check `busy` high in cycles 1..195.
- Edge handling:
  - Load bits {0,1,7}, `step_count`=1.
  - Without `LIFE_TORUS_EN` → `grid_out`=0.
  - With it → bits {0,8,56} only.
- Ignored requests: `start` and `load` pulsed in cycle 20 of a run → no effect; a single `done` in cycle 66; `grid_out` is the blinker result.
- Simultaneous load+start in IDLE → grid loaded, `generation`=0, `busy` stays 0, no `done`.
- Reset in cycle 30 of a run → next cycle: IDLE, `grid_out`=0, `generation`=0, `busy`=0, no `done` pulse.
